fitmerge_45_to_55: RTL

Collects the fit results of the 4-of-5 sub-combinations produced from one 5/5 hit combination and merges them back into a single result per original combination. It keeps the candidate with the lowest chi2 and reports which layer was dropped. It sits downstream of the fitter, on the opposite end of the 55→45 hit multiplexing path. Ordinary 5/5 and 4/5 combinations (single fit) pass through with one cycle of latency.

---
 rtl/fitmerge_45_to_55.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fitmerge_45_to_55.sv
// Merges the 4-of-5 fit results of one 5/5 combination into a single lowest-chi2 result.
// Optional chi2 acceptance cut: define FITMERGE_CHI2_CUT_EN.
module fitmerge_45_to_55 #(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       CHI2_W   = 16,
    parameter logic [CHI2_W-1:0] CHI2_MAX = CHI2_W'(16'hFFFF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic [CHI2_W-1:0] res_chi2,
    input  logic [2:0]        res_sel,
    input  logic              res_is_45,
    input  logic              res_last,
    input  logic              res_ee,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHI2_W-1:0] out_chi2,
    output logic [2:0]        out_sel,
    output logic [2:0]        out_nfit,
    output logic              out_good,
    output logic              out_ee,
    output logic              err
);

    localparam int unsigned NFIT_MAX = 5;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   best_data_q;
    logic [CHI2_W-1:0]   best_chi2_q;
    logic [2:0]          best_sel_q;
    logic                best_vld_q;
    logic [2:0]          nfit_q;
    logic [4:0]          seen_q;
    logic                is45_q;

    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [CHI2_W-1:0]   out_chi2_q;
    logic [2:0]          out_sel_q;
    logic [2:0]          out_nfit_q;
    logic                out_good_q;
    logic                out_ee_q;
    logic                err_q;

    logic                accept;
    logic                in_grp;
    logic                elig;
    logic                take;
    logic [DATA_W-1:0]   new_data;
    logic [CHI2_W-1:0]   new_chi2;
    logic [2:0]          new_sel;
    logic [2:0]          nfit_new;
    logic [4:0]          sel_oh;
    logic                proto_err;

    assign res_ready = !out_valid_q || out_ready;
    assign accept    = res_valid && res_ready;
    assign in_grp    = (state_q == ST_ACC);

`ifdef FITMERGE_CHI2_CUT_EN
    assign elig = (res_chi2 <= CHI2_MAX);
`else
    logic unused_cut;
    assign unused_cut = ^CHI2_MAX;
    assign elig       = 1'b1;
`endif

    // Best/count registers are cleared in IDLE, so the first word of a group uses the same merge.
    always_comb begin
        take     = elig && (!best_vld_q || (res_chi2 < best_chi2_q));
        new_data = take ? res_data : best_data_q;
        new_chi2 = take ? res_chi2 : best_chi2_q;
        new_sel  = take ? res_sel  : best_sel_q;
        nfit_new = nfit_q;
        if (elig && (nfit_q != 3'(NFIT_MAX))) begin
            nfit_new = nfit_q + 3'd1;
        end
    end

    always_comb begin
        sel_oh = 5'b0;
        case (res_sel)
            3'd1:    sel_oh = 5'b00001;
            3'd2:    sel_oh = 5'b00010;
            3'd3:    sel_oh = 5'b00100;
            3'd4:    sel_oh = 5'b01000;
            3'd5:    sel_oh = 5'b10000;
            default: sel_oh = 5'b0;
        endcase
    end

    // A group word is any word of a multi-word group, including the one that opens it.
    always_comb begin
        proto_err = 1'b0;
        if (!res_is_45 && !res_last)                              proto_err = 1'b1;
        if (res_sel > 3'd5)                                       proto_err = 1'b1;
        if ((in_grp || !res_last) && (res_sel == 3'd0))           proto_err = 1'b1;
        if (in_grp && ((seen_q & sel_oh) != 5'b0))                proto_err = 1'b1;
        if (in_grp && (res_is_45 != is45_q))                      proto_err = 1'b1;
        if (res_ee && !res_last)                                  proto_err = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            best_data_q <= '0;
            best_chi2_q <= '0;
            best_sel_q  <= 3'd0;
            best_vld_q  <= 1'b0;
            nfit_q      <= 3'd0;
            seen_q      <= 5'b0;
            is45_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chi2_q  <= '0;
            out_sel_q   <= 3'd0;
            out_nfit_q  <= 3'd0;
            out_good_q  <= 1'b0;
            out_ee_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (proto_err) begin
                    err_q <= 1'b1;
                end
                if (res_last) begin
                    state_q     <= ST_IDLE;
                    best_vld_q  <= 1'b0;
                    best_data_q <= '0;
                    best_chi2_q <= '0;
                    best_sel_q  <= 3'd0;
                    nfit_q      <= 3'd0;
                    seen_q      <= 5'b0;
                    if (nfit_new != 3'd0) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= new_data;
                        out_chi2_q  <= new_chi2;
                        out_sel_q   <= new_sel;
                        out_nfit_q  <= nfit_new;
                        out_good_q  <= 1'b1;
                        out_ee_q    <= res_ee;
                    end else if (res_ee) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= '0;
                        out_chi2_q  <= '1;
                        out_sel_q   <= 3'd0;
                        out_nfit_q  <= 3'd0;
                        out_good_q  <= 1'b0;
                        out_ee_q    <= 1'b1;
                    end
                end else begin
                    state_q     <= ST_ACC;
                    best_data_q <= new_data;
                    best_chi2_q <= new_chi2;
                    best_sel_q  <= new_sel;
                    best_vld_q  <= best_vld_q || take;
                    nfit_q      <= nfit_new;
                    seen_q      <= seen_q | sel_oh;
                    if (!in_grp) begin
                        is45_q <= res_is_45;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chi2  = out_chi2_q;
    assign out_sel   = out_sel_q;
    assign out_nfit  = out_nfit_q;
    assign out_good  = out_good_q;
    assign out_ee    = out_ee_q;
    assign err       = err_q;

endmodule
